// File: rtl/button_light_pkg.sv
// Shared constants for the push-button lamp controller.
// Mode encoding and default timing parameters.
package button_light_pkg;

  localparam int DEF_DEBOUNCE_CYC = 4;
  localparam int DEF_LONG_CYC     = 16;
  localparam int DEF_BLINK_HALF   = 8;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2
  } mode_t;

endpackage

// File: rtl/button_light_ctrl_btn_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer.
// btn_db only changes after DEBOUNCE_CYC consecutive differing cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic btn_db
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          btn_s;
  logic [DW-1:0] db_cnt;

  // bring the raw button into the clock domain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= button;
      btn_s <= sync1;
    end
  end

  // accept a new level only after it has held long enough
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt <= '0;
      btn_db <= 1'b0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt <= '0;
      btn_db <= btn_s;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/button_light_ctrl.sv
// Press classifier and lamp mode sequencer.
// Short press toggles OFF/ON, long press enters or leaves BLINK.
module button_light_ctrl
  import button_light_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int BLINK_HALF   = DEF_BLINK_HALF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button,
  output logic       light,
  output logic [1:0] mode,
  output logic       press_short,
  output logic       press_long
);

  localparam int HW = $clog2(LONG_CYC + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(LONG_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic          btn_db;
  logic          btn_db_q;
  logic          rise;
  logic          fall;
  logic          long_hit;
  logic          long_done;
  logic [HW-1:0] hold_cnt;
  logic [BW-1:0] blink_cnt;
  mode_t         state;
  mode_t         state_nx;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_db (
    .clk   (clk),
    .rst_n (rst_n),
    .button(button),
    .btn_db(btn_db)
  );

  assign rise = btn_db & ~btn_db_q;
  assign fall = ~btn_db & btn_db_q;
  // the rise term guards against a stale count left by a previous press
  assign long_hit = btn_db && !rise && !long_done
                    && (hold_cnt == HOLD_LAST);

  // classify each debounced press, one event per press
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_db_q    <= 1'b0;
      hold_cnt    <= '0;
      long_done   <= 1'b0;
      press_short <= 1'b0;
      press_long  <= 1'b0;
    end else begin
      btn_db_q    <= btn_db;
      press_long  <= long_hit;
      press_short <= fall && !long_done;
      if (rise || !btn_db)
        hold_cnt <= '0;
      else if (hold_cnt != HOLD_MAX)
        hold_cnt <= hold_cnt + 1'b1;
      if (fall)
        long_done <= 1'b0;
      else if (long_hit)
        long_done <= 1'b1;
    end
  end

  // mode state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= MODE_OFF;
    else        state <= state_nx;
  end

  // mode transitions on press events
  always_comb begin
    state_nx = state;
    unique case (state)
      MODE_OFF: begin
        if (press_short)     state_nx = MODE_ON;
        else if (press_long) state_nx = MODE_BLINK;
      end
      MODE_ON: begin
        if (press_short)     state_nx = MODE_OFF;
        else if (press_long) state_nx = MODE_BLINK;
      end
      MODE_BLINK: begin
        if (press_short || press_long) state_nx = MODE_OFF;
      end
      default: state_nx = MODE_OFF;
    endcase
  end

  // mode output
  always_comb begin
    mode = state;
  end

  // lamp drive, updated alongside the mode register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      light     <= 1'b0;
      blink_cnt <= '0;
    end else if (state_nx != state) begin
      blink_cnt <= '0;
      light     <= (state_nx == MODE_BLINK) || (state_nx == MODE_ON);
    end else if (state == MODE_BLINK) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        light     <= ~light;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      blink_cnt <= '0;
      light     <= (state == MODE_ON);
    end
  end

endmodule

// File: tb/tb_button_light_ctrl.sv
// Scoreboard bench for button_light_ctrl.
// Stimulus queues expected events; a monitor checks each pulse.
module tb_button_light_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button = 1'b0;
  logic       light;
  logic [1:0] mode;
  logic       press_short;
  logic       press_long;

  typedef struct {
    logic       is_long;
    logic [1:0] mode;
    logic       light;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  button_light_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button     (button),
    .light      (light),
    .mode       (mode),
    .press_short(press_short),
    .press_long (press_long)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic lg, input logic [1:0] m,
                      input logic l);
    ev_t e;
    e.is_long = lg;
    e.mode    = m;
    e.light   = l;
    exp_q.push_back(e);
  endtask

  task automatic press(input int n);
    button = 1'b1;
    cyc(n);
    button = 1'b0;
    cyc(20);
  endtask

  // monitor: every pulse must match the next queued event
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (press_short || press_long)) begin
        chk("both_pulses", int'(press_short & press_long), 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse short=%0d long=%0d required none",
                   press_short, press_long);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind_long", int'(press_long), int'(e.is_long));
          @(negedge clk);
          chk("mode_after", int'(mode), int'(e.mode));
          chk("light_after", int'(light), int'(e.light));
        end
      end
    end
  end

  initial begin
    int  k;
    bit  seen;
    // reset with button already held
    rst_n  = 1'b0;
    button = 1'b1;
    cyc(2);
    chk("rst_light", int'(light), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_short", int'(press_short), 0);
    chk("rst_long", int'(press_long), 0);
    // held button becomes a fresh short press
    push(1'b0, 2'd1, 1'b1);
    rst_n = 1'b1;
    press(8);
    // second short press: back to OFF
    push(1'b0, 2'd0, 1'b0);
    press(10);
    push(1'b0, 2'd1, 1'b1);
    press(10);
    chk("on_mode", int'(mode), 1);
    // bounce: toggles shorter than the debounce window
    for (int i = 0; i < 5; i++) begin
      button = 1'b1;
      cyc(2);
      button = 1'b0;
      cyc(2);
    end
    cyc(20);
    chk("bounce_mode", int'(mode), 1);
    chk("bounce_light", int'(light), 1);
    // long press from ON enters BLINK
    push(1'b1, 2'd2, 1'b1);
    button = 1'b1;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      if (press_long) seen = 1'b1;
    end
    chk("long_seen", int'(seen), 1);
    chk("long_latency_ok", int'(k >= 20 && k <= 26), 1);
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      chk("blink_light", int'(light), int'(((j / 8) % 2) == 0));
    end
    button = 1'b0;
    cyc(20);
    chk("blink_hold_mode", int'(mode), 2);
    // short press leaves BLINK
    push(1'b0, 2'd0, 1'b0);
    press(10);
    // long into BLINK, long out of BLINK
    push(1'b1, 2'd2, 1'b1);
    press(30);
    push(1'b1, 2'd0, 1'b0);
    press(30);
    chk("long_exit_mode", int'(mode), 0);
    // reset mid-press while blinking
    push(1'b1, 2'd2, 1'b1);
    press(30);
    chk("reblink_mode", int'(mode), 2);
    button = 1'b1;
    cyc(8);
    rst_n = 1'b0;
    button = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("midrst_mode", int'(mode), 0);
    chk("midrst_light", int'(light), 0);
    cyc(40);
    chk("post_rst_mode", int'(mode), 0);
    chk("post_rst_light", int'(light), 0);
    // every queued event must have been observed
    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event long=%0d actual=none required=pulse",
               e.is_long);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
